// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a push-side FIFO feeding a bit-timing FSM
// that serialises each byte LSB first onto a registered UART_TX line.
module uart_tx_fifo #(
    parameter int CYCLES_PER_BIT = 868,
    parameter int DEPTH_LOG2     = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            DATA,
    input  logic                  VALID,
    output logic                  FULL,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERFLOW,
    output logic                  UART_TX
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(CYCLES_PER_BIT);

    localparam logic [TW-1:0]       BIT_LAST    = TW'(CYCLES_PER_BIT - 1);
    localparam logic [TW-1:0]       BIT_PRELAST = TW'(CYCLES_PER_BIT - 2);
    localparam logic [DEPTH_LOG2:0] DEPTH_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]            mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  full_reg;
    logic                  overflow_reg;

    state_t                state_reg;
    logic [TW-1:0]         timer_reg;
    logic [2:0]            bit_idx_reg;
    logic [7:0]            shift_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic                  done_reg;

    logic                  push;
    logic                  pop;
    logic                  bit_end;
    logic                  fifo_has_data;

    // Acceptance looks only at the pre-edge FULL, so a same-edge pop never frees a slot early.
    assign push          = VALID && !full_reg;
    assign fifo_has_data = (count_reg != '0);
    assign bit_end       = (timer_reg == BIT_LAST);
    assign pop           = fifo_has_data &&
                           ((state_reg == S_IDLE) || ((state_reg == S_STOP) && bit_end));

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_COUNT);
            if (VALID && full_reg) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= S_IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    tx_reg    <= 1'b1;
                    timer_reg <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        state_reg <= S_START;
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        timer_reg   <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= S_DATA;
                        tx_reg      <= shift_reg[0];
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        timer_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= S_STOP;
                            tx_reg    <= 1'b1;
                        end else begin
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                S_STOP: begin
                    // DONE is registered, so it is raised one cycle ahead to land in the last stop cycle.
                    if (timer_reg == BIT_PRELAST) begin
                        done_reg <= 1'b1;
                    end
                    if (bit_end) begin
                        timer_reg <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr_reg];
                            state_reg <= S_START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign FULL     = full_reg;
    assign COUNT    = count_reg;
    assign BUSY     = busy_reg;
    assign DONE     = done_reg;
    assign OVERFLOW = overflow_reg;
    assign UART_TX  = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CYCLES_PER_BIT=4, DEPTH_LOG2=2.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int FRAME = 10 * CPB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     data = 8'h00;
    logic           valid = 1'b0;
    logic           full;
    logic [DL2:0]   count;
    logic           busy;
    logic           done;
    logic           overflow;
    logic           tx;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .CYCLES_PER_BIT(CPB),
        .DEPTH_LOG2    (DL2)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .DATA    (data),
        .VALID   (valid),
        .FULL    (full),
        .COUNT   (count),
        .BUSY    (busy),
        .DONE    (done),
        .OVERFLOW(overflow),
        .UART_TX (tx)
    );

    always #5 clk = ~clk;

    // Expected line level at cycle 'off' (1..FRAME) of a frame carrying byte b.
    function automatic logic exp_line(input logic [7:0] b, input int off);
        if (off <= CPB) return 1'b0;
        if (off <= 9 * CPB) return b[(off - CPB - 1) / CPB];
        return 1'b1;
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx n=%0d got=%b exp=1", n, tx); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy n=%0d got=%b exp=0", n, busy); end
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count n=%0d got=%0d exp=0", n, count); end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full n=%0d got=%b exp=0", n, full); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done n=%0d got=%b exp=0", n, done); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf n=%0d got=%b exp=0", n, overflow); end
        end
        $display("test_reset: done, errors so far %0d", errors);
    endtask

    task automatic test_single;
        logic exp_done;
        do_reset();
        valid = 1'b1;
        data  = 8'hA5;
        for (int n = 0; n <= FRAME + 1; n++) begin
            @(negedge clk);
            if (n == 0) begin
                checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count0 got=%0d exp=1", count); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy0 got=%b exp=0", busy); end
                checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx0 got=%b exp=1", tx); end
            end else if (n <= FRAME) begin
                exp_done = (n == FRAME);
                checks++; if (tx !== exp_line(8'hA5, n)) begin errors++; $display("FAIL single_tx n=%0d got=%b exp=%b", n, tx, exp_line(8'hA5, n)); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy n=%0d got=%b exp=1", n, busy); end
                checks++; if (done !== exp_done) begin errors++; $display("FAIL single_done n=%0d got=%b exp=%b", n, done, exp_done); end
                if (n == 1) begin
                    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count1 got=%0d exp=0", count); end
                end
            end else begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
                checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_end got=%b exp=1", tx); end
            end
            valid = 1'b0;
            data  = 8'hEE;
        end
        $display("test_single: byte 0xA5 sent, errors so far %0d", errors);
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        int         peak;
        int         dones;
        int         last_done;
        int         k;
        int         off;
        logic       exp_done;
        bytes     = '{8'h00, 8'hFF, 8'h55};
        peak      = 0;
        dones     = 0;
        last_done = -1;
        do_reset();
        valid = 1'b1;
        data  = bytes[0];
        for (int n = 0; n <= 3 * FRAME + 1; n++) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
            if (n >= 1 && n <= 3 * FRAME) begin
                k        = (n - 1) / FRAME;
                off      = (n - 1) % FRAME + 1;
                exp_done = (off == FRAME);
                checks++; if (tx !== exp_line(bytes[k], off)) begin errors++; $display("FAIL b2b_tx n=%0d got=%b exp=%b", n, tx, exp_line(bytes[k], off)); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy n=%0d got=%b exp=1", n, busy); end
                checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done n=%0d got=%b exp=%b", n, done, exp_done); end
                if (done === 1'b1) begin
                    dones++;
                    if (last_done >= 0) begin
                        checks++; if (n - last_done != FRAME) begin errors++; $display("FAIL b2b_done_gap got=%0d exp=%0d", n - last_done, FRAME); end
                    end
                    last_done = n;
                end
            end
            if (n == 3 * FRAME + 1) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
                checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_count_end got=%0d exp=0", count); end
            end
            if (n < 2) begin
                valid = 1'b1;
                data  = bytes[n + 1];
            end else begin
                valid = 1'b0;
                data  = 8'hEE;
            end
        end
        checks++; if (peak != 2) begin errors++; $display("FAIL b2b_peak got=%0d exp=2", peak); end
        checks++; if (dones != 3) begin errors++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
        $display("test_back_to_back: 3 frames, errors so far %0d", errors);
    endtask

    task automatic test_full_overflow;
        logic [7:0] bytes [5];
        int         dones;
        int         k;
        int         off;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        dones = 0;
        do_reset();
        valid = 1'b1;
        data  = 8'h11;
        for (int n = 0; n <= 5 * FRAME + 1; n++) begin
            @(negedge clk);
            if (n == 5) begin
                checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_count5 got=%0d exp=3", count); end
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_flag5 got=%b exp=0", full); end
            end
            if (n == 6) begin
                checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count6 got=%0d exp=4", count); end
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag6 got=%b exp=1", full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_ovf6 got=%b exp=0", overflow); end
            end
            if (n == 7) begin
                checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count7 got=%0d exp=4", count); end
            end
            if (n >= 7) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_ovf n=%0d got=%b exp=1", n, overflow); end
            end
            if (n == FRAME + 1) begin
                checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_count_pop got=%0d exp=3", count); end
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_flag_pop got=%b exp=0", full); end
            end
            if (n >= 1 && n <= 5 * FRAME) begin
                k   = (n - 1) / FRAME;
                off = (n - 1) % FRAME + 1;
                checks++; if (tx !== exp_line(bytes[k], off)) begin errors++; $display("FAIL full_tx n=%0d got=%b exp=%b", n, tx, exp_line(bytes[k], off)); end
                if (done === 1'b1) dones++;
            end
            if (n == 5 * FRAME + 1) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got=%b exp=0", busy); end
                checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_count_end got=%0d exp=0", count); end
            end
            if (n >= 2 && n <= 6) begin
                valid = 1'b1;
                data  = 8'h22 + 8'((n - 2) * 8'h11);
            end else begin
                valid = 1'b0;
                data  = 8'hEE;
            end
        end
        checks++; if (dones != 5) begin errors++; $display("FAIL full_dones got=%0d exp=5", dones); end
        $display("test_full_overflow: 5 of 6 bytes sent, errors so far %0d", errors);
    endtask

    task automatic test_simultaneous;
        logic [7:0] bytes [3];
        int         k;
        int         off;
        bytes = '{8'hA1, 8'hB2, 8'hC3};
        do_reset();
        valid = 1'b1;
        data  = 8'hA1;
        for (int n = 0; n <= 3 * FRAME + 1; n++) begin
            @(negedge clk);
            if (n == 1 || n == FRAME || n == FRAME + 1) begin
                checks++; if (count !== 3'd1) begin errors++; $display("FAIL simul_count n=%0d got=%0d exp=1", n, count); end
            end
            if (n == 2 * FRAME + 1) begin
                checks++; if (count !== 3'd0) begin errors++; $display("FAIL simul_count_drain got=%0d exp=0", count); end
            end
            if (n >= 1 && n <= 3 * FRAME) begin
                k   = (n - 1) / FRAME;
                off = (n - 1) % FRAME + 1;
                checks++; if (tx !== exp_line(bytes[k], off)) begin errors++; $display("FAIL simul_tx n=%0d got=%b exp=%b", n, tx, exp_line(bytes[k], off)); end
            end
            if (n == 3 * FRAME + 1) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy_end got=%b exp=0", busy); end
            end
            if (n == 0) begin
                valid = 1'b1;
                data  = 8'hB2;
            end else if (n == FRAME) begin
                valid = 1'b1;
                data  = 8'hC3;
            end else begin
                valid = 1'b0;
                data  = 8'hEE;
            end
        end
        $display("test_simultaneous: order A1 B2 C3, errors so far %0d", errors);
    endtask

    task automatic test_reset_mid;
        do_reset();
        valid = 1'b1;
        data  = 8'h3C;
        for (int n = 0; n <= 80; n++) begin
            @(negedge clk);
            if (n >= 1 && n <= 17) begin
                checks++; if (tx !== exp_line(8'h3C, n)) begin errors++; $display("FAIL rmid_tx n=%0d got=%b exp=%b", n, tx, exp_line(8'h3C, n)); end
            end
            if (n == 3) begin
                checks++; if (count !== 3'd2) begin errors++; $display("FAIL rmid_count_q got=%0d exp=2", count); end
            end
            if (n >= 18) begin
                checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmid_tx_after n=%0d got=%b exp=1", n, tx); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy n=%0d got=%b exp=0", n, busy); end
                checks++; if (count !== 3'd0) begin errors++; $display("FAIL rmid_count n=%0d got=%0d exp=0", n, count); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done n=%0d got=%b exp=0", n, done); end
            end
            rst = (n == 17);
            if (n == 1 || n == 2) begin
                valid = 1'b1;
                data  = 8'(n);
            end else begin
                valid = 1'b0;
                data  = 8'hEE;
            end
        end
        $display("test_reset_mid: frame abandoned, errors so far %0d", errors);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_overflow();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter, the transmit-side counterpart to the byte receiver in the loopback/core path. Core logic pushes bytes with a valid strobe into an internal FIFO. A bit-timing FSM drains the FIFO and serialises each byte onto UART_TX, LSB first. Bursts from the core are absorbed without per-byte handshaking.

Parameters:
CYCLES_PER_BIT, 868, CLK cycles per UART bit (100 MHz / 115200); legal range 2..65535
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries); legal range 1..8

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
DATA  input  8  byte to transmit
VALID  input  1  push strobe; DATA accepted on any edge where VALID=1 and FULL=0
FULL  output  1  FIFO holds 2^DEPTH_LOG2 entries; registered
COUNT  output  DEPTH_LOG2+1  current FIFO occupancy; registered
BUSY  output  1  FSM not in IDLE (frame in progress)
DONE  output  1  one-cycle pulse in the last cycle of each stop bit
OVERFLOW  output  1  sticky; set when VALID=1 while FULL=1; cleared only by RST
UART_TX  output  1  serial line, idle high

Behaviour:
- Reset (RST=1 at an edge): FIFO emptied; COUNT=0, FULL=0, OVERFLOW=0; FSM=IDLE; BUSY=0, DONE=0, UART_TX=1. Takes effect at the next edge even mid-frame. Any partial frame is abandoned and the line returns high.
- FIFO push:
  - Push on an edge with VALID=1 and FULL=0.
  - VALID=1 with FULL=1: byte dropped, OVERFLOW set, COUNT unchanged.
  - FULL is evaluated from the pre-edge COUNT. A push is refused while FULL=1 even if a pop happens on the same edge.
- FIFO pop: FSM pops one entry on entering START. Push and pop on the same edge leave COUNT unchanged. Pointers wrap modulo 2^DEPTH_LOG2.
- FSM states:
  - IDLE: UART_TX=1. If COUNT>0, pop into the shift register, go to START.
  - START: UART_TX=0 for CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: UART_TX=shift[0] for CYCLES_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: UART_TX=1 for CYCLES_PER_BIT cycles. DONE=1 in the final cycle. Then:
    - COUNT>0: pop and go directly to START, with no idle cycle between frames.
    - else: go to IDLE.
- Bit timer: counter from 0 to CYCLES_PER_BIT-1, reset on every state/bit change. Width is clog2(CYCLES_PER_BIT).
- Frame length is exactly 10*CYCLES_PER_BIT cycles.
- Latency: a byte pushed at edge E into an empty FIFO with FSM=IDLE causes UART_TX=0 starting after edge E+1.
- BUSY=1 in START/DATA/STOP.
- UART_TX is driven from a register (glitch-free).
- DATA is sampled only at the push edge; later changes do not affect a queued byte.

Test Plan:
- Reset/idle (CYCLES_PER_BIT=4, DEPTH_LOG2=2): hold RST 3 cycles, release, no VALID for 50 cycles -> UART_TX=1, BUSY=0, COUNT=0, FULL=0, DONE never pulses.
- Single byte: push 0xA5 one cycle at edge E -> UART_TX low from E+1 for 4 cycles. Bits then read 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4. DONE pulses at cycle E+40. BUSY is high cycles E+1..E+40.
- Back-to-back burst: push 0x00, 0xFF, 0x55 on consecutive edges -> three contiguous 40-cycle frames with no idle gap. COUNT peaks at 2. Exactly three DONE pulses, 40 cycles apart.
- Full/overflow: during the first frame, push 5 more bytes at depth 4 -> FULL=1 after the 4th stored byte, 5th dropped, OVERFLOW=1 and stays set. Only the accepted bytes appear on the line, in order.
- Simultaneous push/pop: with COUNT=1, push on the same edge as the STOP->START pop -> COUNT stays 1 and the byte order is preserved.
- Reset mid-frame: assert RST during DATA bit 3 of 0x3C with 2 bytes queued -> after the next edge UART_TX=1, COUNT=0, BUSY=0. No further frames until a new push.
